mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory port stage directly downstream of the multicycle controller.
//  - Takes one access request per memory state (memwrite, lb size code, address).
//  - Drives a variable-latency memory handshake and holds the controller stalled via busy.
//  - Returns formatted load data (byte/half extract, sign/zero extend) for the IR/data register path.
//  - Big-endian lanes: byte offset 0 = bits [31:24].
// PARAMETERS
//  AW       32  address width (bits)
//  DW       32  data width (fixed at 32; other values unsupported)
//  MAXWAIT  15  cycles without mem_ack before abort with err
// PORTS
//  clk       in   1       clock, rising edge
//  reset     in   1       asynchronous, active-low reset
//  req       in   1       start access (1-cycle pulse from controller)
//  we        in   1       1 = store, 0 = load (controller memwrite)
//  lb        in   2       size: 00 word, 01 byte sign-ext, 10 byte zero-ext, 11 half sign-ext
//  adr       in   AW      byte address
//  wd        in   DW      store data (right-aligned)
//  rd        out  DW      formatted load data, registered
//  busy      out  1       access in flight; controller holds its state while high
//  done      out  1       1-cycle pulse: access complete
//  err       out  1       1-cycle pulse: misaligned access or timeout
//  mem_req   out  1       memory request, held until mem_ack
//  mem_we    out  1       memory write strobe
//  mem_adr   out  AW      word-aligned address (adr[1:0] forced 00)
//  mem_be    out  4       byte enables, bit3 = lane [31:24]
//  mem_wd    out  DW      lane-replicated store data
//  mem_ack   in   1       memory done; mem_rd valid same cycle for loads
//  mem_rd    in   DW      raw memory read word
// BEHAVIOUR
//  Reset values:
//   - rd = 0; busy, done, err, mem_req, mem_we = 0; mem_adr, mem_be, mem_wd = 0.
//   - FSM in IDLE; wait counter = 0.
//   - Reset mid-access drops mem_req asynchronously; no done/err is generated.
//  FSM states: IDLE, ACCESS, DONE, ERR.
//   IDLE:
//    - On req, evaluate alignment: word needs adr[1:0]=00; half needs adr[0]=0; byte is always aligned.
//    - Misaligned -> ERR. Memory is not touched.
//    - Aligned -> ACCESS. Latch we/lb/adr/wd; next edge raises mem_req, mem_we, mem_adr, mem_be, mem_wd.
//   ACCESS:
//    - busy=1; mem_* held stable.
//    - mem_ack: load -> rd <= fmt(mem_rd); go to DONE. Store -> rd unchanged; go to DONE.
//    - mem_ack and timeout in the same cycle: ack wins.
//    - No ack for MAXWAIT cycles -> ERR; mem_req drops.
//   DONE: done=1 for one cycle, busy=0, mem_req=0 -> IDLE.
//   ERR: err=1 for one cycle, busy=0 -> IDLE. rd unchanged.
//  busy is high from the cycle after req through the ack cycle. req while busy is ignored.
//  Latency with ack in the first ACCESS cycle: req@0, mem_req@1, done@2.
//  Store lanes:
//   - word: be=1111, wd as-is.
//   - half: {2{wd[15:0]}}; be=1100 at off 0, 0011 at off 2.
//   - byte: {4{wd[7:0]}}; be one-hot, off 0 -> 1000 ... off 3 -> 0001.
//   - mem_be=0000 for all loads.
//  Load format: select the lane by offset; 01/11 sign-extend from the lane MSB; 10 zero-extends.
//  Wait counter is 4 bits wide. It resets on entry to ACCESS and saturates; no wrap.
// STRUCTURE
//  - mem_pkg: typedef enum logic [1:0] size_t {SZ_W, SZ_BS, SZ_BU, SZ_HS}; state enum;
//    BE_WORD/BE_NONE constants.
//  - Sub-module lane_fmt (combinational): (mem_rd, off, size) -> rd_next; (wd, off, size) -> mem_wd, mem_be.
//  - Top: FSM, registers, wait counter.
// TESTING
//  - Word load: adr=0x10, lb=00, mem_rd=0xDEADBEEF, ack after 3 cycles
//    -> mem_adr=0x10, busy 4 cycles, done pulse, rd=0xDEADBEEF.
//  - Byte signed/unsigned: adr=0x13, mem_rd=0x000000F0
//    -> lb=01 gives rd=0xFFFFFFF0; lb=10 gives rd=0x000000F0.
//  - Half store: adr=0x22, wd=0x1234ABCD, we=1
//    -> mem_adr=0x20, mem_be=0011, mem_wd=0xABCDABCD, done, rd unchanged.
//  - Misaligned: word at adr=0x6
//    -> err pulse the next cycle, mem_req never asserted, busy stays 0.
//  - Timeout: no ack -> err after MAXWAIT=15 ACCESS cycles, mem_req drops. A following access completes normally.
//  - Reset low during ACCESS -> mem_req/busy 0 immediately, rd=0, no done; next req after release works.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and constants for the memory access unit:
//                access size codes, FSM state encoding, byte-enable
//                constants and the alignment rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Size code as issued by the controller on lb.
  typedef enum logic [1:0] {
    SZ_W  = 2'b00,  // word
    SZ_BS = 2'b01,  // byte, sign-extended
    SZ_BU = 2'b10,  // byte, zero-extended
    SZ_HS = 2'b11   // half, sign-extended
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10,
    ST_ERR    = 2'b11
  } state_t;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  // Word needs offset 00, half needs an even offset, byte is always aligned.
  function automatic logic is_aligned(input size_t size, input logic [1:0] off);
    logic ok;
    ok = 1'b1;
    case (size)
      SZ_W:    ok = (off == 2'b00);
      SZ_HS:   ok = (off[0] == 1'b0);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : lane_fmt
//  Description : Combinational big-endian lane steering.
//                Read path : picks the byte/half lane out of the raw memory
//                            word and sign/zero-extends it.
//                Write path: replicates store data across lanes and builds
//                            the matching byte enables.
//                Lane order: offset 0 = bits [31:24].
//  Ports       : mem_rd   in  32  raw memory word
//                rd_off   in  2   byte offset of the load
//                rd_size  in  2   size code of the load
//                wd       in  32  right-aligned store data
//                wr_off   in  2   byte offset of the store
//                wr_size  in  2   size code of the store
//                rd_next  out 32  formatted load data
//                mem_wd   out 32  lane-replicated store data
//                mem_be   out 4   store byte enables (bit3 = [31:24])
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_fmt
  import mem_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [1:0]  rd_off,
  input  logic [1:0]  rd_size,
  input  logic [31:0] wd,
  input  logic [1:0]  wr_off,
  input  logic [1:0]  wr_size,
  output logic [31:0] rd_next,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_be
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = mem_rd[31:24];
    case (rd_off)
      2'd0:    byte_lane = mem_rd[31:24];
      2'd1:    byte_lane = mem_rd[23:16];
      2'd2:    byte_lane = mem_rd[15:8];
      default: byte_lane = mem_rd[7:0];
    endcase
    // Halves are only legal at offsets 0 and 2, so bit 1 picks the lane.
    half_lane = rd_off[1] ? mem_rd[15:0] : mem_rd[31:16];

    rd_next = mem_rd;
    case (size_t'(rd_size))
      SZ_W:    rd_next = mem_rd;
      SZ_BS:   rd_next = {{24{byte_lane[7]}}, byte_lane};
      SZ_BU:   rd_next = {24'h000000, byte_lane};
      default: rd_next = {{16{half_lane[15]}}, half_lane};
    endcase
  end

  always_comb begin
    mem_wd = wd;
    mem_be = BE_WORD;
    case (size_t'(wr_size))
      SZ_W: begin
        mem_wd = wd;
        mem_be = BE_WORD;
      end
      SZ_HS: begin
        mem_wd = {2{wd[15:0]}};
        mem_be = wr_off[1] ? 4'b0011 : 4'b1100;
      end
      default: begin
        mem_wd = {4{wd[7:0]}};
        mem_be = 4'b1000 >> wr_off;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Memory port stage behind the multicycle controller. Accepts
//                one request, checks alignment, runs a variable-latency
//                mem_req/mem_ack handshake with a timeout, and returns
//                formatted load data. busy stalls the controller meanwhile.
//  Ports       : clk      in  1   clock, rising edge
//                reset    in  1   asynchronous active-low reset
//                req      in  1   start access (1-cycle pulse)
//                we       in  1   1 = store, 0 = load
//                lb       in  2   size code (00 W, 01 BS, 10 BU, 11 HS)
//                adr      in  AW  byte address
//                wd       in  DW  right-aligned store data
//                rd       out DW  formatted load data (registered)
//                busy     out 1   access in flight
//                done     out 1   completion pulse
//                err      out 1   misalign / timeout pulse
//                mem_req  out 1   memory request, held until mem_ack
//                mem_we   out 1   memory write strobe
//                mem_adr  out AW  word-aligned address
//                mem_be   out 4   byte enables, bit3 = [31:24]
//                mem_wd   out DW  lane-replicated store data
//                mem_ack  in  1   memory done, mem_rd valid with it
//                mem_rd   in  DW  raw memory read word
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAXWAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    lb,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [3:0]    mem_be,
  output logic [DW-1:0] mem_wd,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rd
);

  // Last counter value at which a missing ack is still tolerated.
  localparam logic [3:0] WAIT_LAST = 4'(MAXWAIT - 1);

  state_t        state_q,   state_d;
  logic [3:0]    cnt_q,     cnt_d;
  logic [DW-1:0] rd_q,      rd_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q,  mem_we_d;
  logic [AW-1:0] mem_adr_q, mem_adr_d;
  logic [3:0]    mem_be_q,  mem_be_d;
  logic [DW-1:0] mem_wd_q,  mem_wd_d;
  size_t         size_q,    size_d;
  logic [1:0]    off_q,     off_d;

  logic [DW-1:0] fmt_rd;
  logic [DW-1:0] fmt_wd;
  logic [3:0]    fmt_be;

  // Read path formats with the latched request; write path formats the
  // incoming request so the lanes are ready when mem_req rises.
  lane_fmt u_lane_fmt (
    .mem_rd  (mem_rd),
    .rd_off  (off_q),
    .rd_size (size_q),
    .wd      (wd),
    .wr_off  (adr[1:0]),
    .wr_size (lb),
    .rd_next (fmt_rd),
    .mem_wd  (fmt_wd),
    .mem_be  (fmt_be)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    mem_adr_d = mem_adr_q;
    mem_be_d  = mem_be_q;
    mem_wd_d  = mem_wd_q;
    size_d    = size_q;
    off_d     = off_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (is_aligned(size_t'(lb), adr[1:0])) begin
            state_d   = ST_ACCESS;
            cnt_d     = 4'd0;
            size_d    = size_t'(lb);
            off_d     = adr[1:0];
            mem_req_d = 1'b1;
            mem_we_d  = we;
            mem_adr_d = {adr[AW-1:2], 2'b00};
            mem_be_d  = we ? fmt_be : BE_NONE;
            mem_wd_d  = fmt_wd;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ACCESS: begin
        // An ack in the timeout cycle is checked first, so it wins.
        if (mem_ack) begin
          if (!mem_we_q) begin
            rd_d = fmt_rd;
          end
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_DONE;
        end else if (cnt_q == WAIT_LAST) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_ERR;
        end else if (cnt_q != 4'hF) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      rd_q      <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_adr_q <= '0;
      mem_be_q  <= BE_NONE;
      mem_wd_q  <= '0;
      size_q    <= SZ_W;
      off_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      mem_adr_q <= mem_adr_d;
      mem_be_q  <= mem_be_d;
      mem_wd_q  <= mem_wd_d;
      size_q    <= size_d;
      off_q     <= off_d;
    end
  end

  assign rd      = rd_q;
  assign busy    = (state_q == ST_ACCESS);
  assign done    = (state_q == ST_DONE);
  assign err     = (state_q == ST_ERR);
  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;
  assign mem_adr = mem_adr_q;
  assign mem_be  = mem_be_q;
  assign mem_wd  = mem_wd_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Scoreboard bench for mem_access_unit. Each access pushes its
//                expected outcome (err/done and rd) to a queue; a monitor
//                pops and compares on every done/err pulse. The access task
//                also checks the memory-side signals, latency and busy time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  typedef struct packed {
    logic        is_err;
    logic [31:0] rd;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  lb;
  logic [31:0] adr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wd;
  logic        mem_ack;
  logic [31:0] mem_rd;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  logic [31:0] model_rd = 32'h0;

  mem_access_unit #(.AW(32), .DW(32), .MAXWAIT(15)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .we      (we),
    .lb      (lb),
    .adr     (adr),
    .wd      (wd),
    .rd      (rd),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .mem_adr (mem_adr),
    .mem_be  (mem_be),
    .mem_wd  (mem_wd),
    .mem_ack (mem_ack),
    .mem_rd  (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---- reference model -----------------------------------------------------
  function automatic logic model_aligned(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'b00) return off == 2'b00;
    if (sz == 2'b11) return off[0] == 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_fmt(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * (3 - int'(off)))) & 32'h0000_00FF;
    h = (w >> (16 * (1 - int'(off[1])))) & 32'h0000_FFFF;
    case (sz)
      2'b00:   return w;
      2'b01:   return b[7] ? (b | 32'hFFFF_FF00) : b;
      2'b10:   return b;
      default: return h[15] ? (h | 32'hFFFF_0000) : h;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic w, input logic [1:0] sz,
                                          input logic [1:0] off);
    if (!w) return 4'b0000;
    if (sz == 2'b00) return 4'b1111;
    if (sz == 2'b11) return (off == 2'd0) ? 4'b1100 : 4'b0011;
    case (off)
      2'd0:    return 4'b1000;
      2'd1:    return 4'b0100;
      2'd2:    return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [31:0] model_wd(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'b00) return d;
    if (sz == 2'b11) return {d[15:0], d[15:0]};
    return {d[7:0], d[7:0], d[7:0], d[7:0]};
  endfunction

  // ---- scoreboard monitor --------------------------------------------------
  always @(negedge clk) begin
    if (reset && (done || err)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_resp", {30'h0, done, err}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("resp_err",  {31'h0, err},  {31'h0, e.is_err});
        check_eq("resp_done", {31'h0, done}, {31'h0, !e.is_err});
        check_eq("resp_rd",   rd, e.rd);
      end
    end
  end

  // ---- one access; ack_after < 0 means the memory never acks ---------------
  task automatic run_access(input string name, input logic w, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] mrd, input int ack_after);
    logic aligned;
    int   exp_lat;
    int   cyc;
    int   busy_cnt;
    logic saw_req;
    exp_t e;

    aligned = model_aligned(sz, a[1:0]);
    if (aligned && !w && ack_after >= 0 && ack_after < 15)
      model_rd = model_fmt(mrd, sz, a[1:0]);
    e.is_err = !aligned || ack_after < 0 || ack_after >= 15;
    e.rd     = model_rd;
    exp_q.push_back(e);
    exp_lat  = !aligned ? 0 : ((ack_after < 0 || ack_after >= 15) ? 15 : ack_after + 1);

    @(negedge clk);
    req = 1'b1; we = w; lb = sz; adr = a; wd = d;
    @(negedge clk);
    req = 1'b0;
    cyc = 0; busy_cnt = 0; saw_req = 1'b0;
    while (!(done || err) && cyc < 40) begin
      if (busy) busy_cnt++;
      if (mem_req) saw_req = 1'b1;
      if (cyc == 0) begin
        check_eq({name, "_mem_adr"}, mem_adr, {a[31:2], 2'b00});
        check_eq({name, "_mem_be"},  {28'h0, mem_be}, {28'h0, model_be(w, sz, a[1:0])});
        check_eq({name, "_mem_we"},  {31'h0, mem_we}, {31'h0, w});
        if (w) check_eq({name, "_mem_wd"}, mem_wd, model_wd(d, sz));
      end
      // A second request while busy must be ignored.
      req     = (cyc == 1);
      mem_ack = (ack_after >= 0 && cyc == ack_after);
      mem_rd  = mem_ack ? mrd : ~mrd;
      @(negedge clk);
      mem_ack = 1'b0;
      req     = 1'b0;
      cyc++;
    end
    if (cyc >= 40) check_eq({name, "_no_response"}, 32'h1, 32'h0);
    check_eq({name, "_latency"},   cyc, exp_lat);
    check_eq({name, "_busy_cyc"},  busy_cnt, exp_lat);
    check_eq({name, "_saw_req"},   {31'h0, saw_req}, {31'h0, aligned});
    check_eq({name, "_req_low"},   {31'h0, mem_req}, 32'h0);
    check_eq({name, "_busy_low"},  {31'h0, busy}, 32'h0);
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; we = 1'b0; lb = 2'b00; adr = 32'h0; wd = 32'h0;
    mem_ack = 1'b0; mem_rd = 32'h0;

    repeat (2) @(negedge clk);
    check_eq("rst_rd",      rd, 32'h0);
    check_eq("rst_flags",   {28'h0, busy, done, err, mem_req}, 32'h0);
    check_eq("rst_mem_we",  {31'h0, mem_we}, 32'h0);
    check_eq("rst_mem_adr", mem_adr, 32'h0);
    check_eq("rst_mem_be",  {28'h0, mem_be}, 32'h0);
    check_eq("rst_mem_wd",  mem_wd, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    run_access("ld_word",   1'b0, 2'b00, 32'h10, 32'h0, 32'hDEAD_BEEF, 3);
    run_access("ld_bs",     1'b0, 2'b01, 32'h13, 32'h0, 32'h0000_00F0, 0);
    run_access("ld_bu",     1'b0, 2'b10, 32'h13, 32'h0, 32'h0000_00F0, 0);
    run_access("st_half",   1'b1, 2'b11, 32'h22, 32'h1234_ABCD, 32'h0, 1);
    run_access("mis_word",  1'b0, 2'b00, 32'h06, 32'h0, 32'h0, 0);
    run_access("ld_hs",     1'b0, 2'b11, 32'h22, 32'h0, 32'h1234_8001, 2);
    run_access("mis_half",  1'b1, 2'b11, 32'h21, 32'h5555_5555, 32'h0, 0);
    run_access("st_byte",   1'b1, 2'b01, 32'h11, 32'hCAFE_F05A, 32'h0, 0);
    run_access("st_word",   1'b1, 2'b00, 32'h44, 32'h0102_0304, 32'h0, 2);
    run_access("timeout",   1'b0, 2'b00, 32'h40, 32'h0, 32'h1111_1111, -1);
    run_access("after_to",  1'b0, 2'b10, 32'h40, 32'h0, 32'h0080_0000, 0);
    run_access("ack_last",  1'b0, 2'b01, 32'h42, 32'h0, 32'h0000_8000, 14);

    for (int i = 0; i < 8; i++) begin
      run_access("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 $urandom & 32'h0000_00FF, $urandom, $urandom, $urandom_range(0, 4));
    end
    // Leave rd non-zero so the reset-clears-rd check means something.
    run_access("ld_pre_rst", 1'b0, 2'b00, 32'h80, 32'h0, 32'hA5A5_0F0F, 0);

    // Reset in the middle of an access.
    @(negedge clk);
    req = 1'b1; we = 1'b0; lb = 2'b00; adr = 32'h84;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("mid_busy", {31'h0, busy}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_mem_req", {31'h0, mem_req}, 32'h0);
    check_eq("arst_busy",    {31'h0, busy}, 32'h0);
    check_eq("arst_rd",      rd, 32'h0);
    model_rd = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("arst_no_done", {30'h0, done, err}, 32'h0);
    run_access("post_rst", 1'b0, 2'b11, 32'h86, 32'h0, 32'h0000_7FFF, 1);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
